// File: rtl/cpu_pkg.sv
//------------------------------------------------------------------------------
// cpu_pkg : shared load-width codes, load FSM state type and legality helper.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } ld_state_t;

    // True when the width code is undefined or the byte offset breaks its alignment.
    function automatic logic ld_is_bad(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_LB, F3_LBU: return 1'b0;
            F3_LH, F3_LHU: return off[0];
            F3_LW:         return |off;
            default:       return 1'b1;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/load_unit_if.sv
//------------------------------------------------------------------------------
// load_unit_if : execute-side request, data-RAM read port and write-back result.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface load_unit_if;

    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [2:0]  ld_funct3;
    logic        ld_ready;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] RAMI;
    logic        ld_done;
    logic        ld_err;
    logic        stall;

    modport master (
        output ld_valid, ld_addr, ld_funct3, mem_ready, mem_rdata,
        input  ld_ready, mem_req, mem_addr, RAMI, ld_done, ld_err, stall
    );

    modport slave (
        input  ld_valid, ld_addr, ld_funct3, mem_ready, mem_rdata,
        output ld_ready, mem_req, mem_addr, RAMI, ld_done, ld_err, stall
    );

endinterface

`default_nettype wire

// File: rtl/load_extract.sv
//------------------------------------------------------------------------------
// load_extract : lane select and sign/zero extension of a returned RAM word.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module load_extract
    import cpu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{off, 3'b000} +: 8];
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  data = {24'd0, byte_sel};
            F3_LHU:  data = {16'd0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/load_unit.sv
//------------------------------------------------------------------------------
// load_unit : single-outstanding load FSM with RAM handshake, timeout and stall.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module load_unit
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    load_unit_if.slave bus
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    ld_state_t   state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] rami_q, rami_d;
    logic        mem_req_q, ld_done_q, ld_err_q;
    logic [31:0] ext_data;

    load_extract u_extract (
        .rdata  (bus.mem_rdata),
        .off    (off_q),
        .funct3 (f3_q),
        .data   (ext_data)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        off_d      = off_q;
        f3_d       = f3_q;
        mem_addr_d = mem_addr_q;
        rami_d     = rami_q;
        case (state_q)
            S_IDLE: begin
                if (bus.ld_valid) begin
                    if (ld_is_bad(bus.ld_funct3, bus.ld_addr[1:0])) begin
                        state_d = S_ERR;
                    end else begin
                        state_d    = S_REQ;
                        off_d      = bus.ld_addr[1:0];
                        f3_d       = bus.ld_funct3;
                        mem_addr_d = {bus.ld_addr[31:2], 2'b00};
                        cnt_d      = 8'd0;
                    end
                end
            end
            S_REQ: begin
                // Ready is checked first so a response on the terminal cycle still completes.
                if (bus.mem_ready) begin
                    rami_d  = ext_data;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            off_q      <= 2'd0;
            f3_q       <= 3'd0;
            mem_addr_q <= 32'd0;
            rami_q     <= 32'd0;
            mem_req_q  <= 1'b0;
            ld_done_q  <= 1'b0;
            ld_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            off_q      <= off_d;
            f3_q       <= f3_d;
            mem_addr_q <= mem_addr_d;
            rami_q     <= rami_d;
            mem_req_q  <= (state_d == S_REQ);
            ld_done_q  <= (state_d == S_DONE);
            ld_err_q   <= (state_d == S_ERR);
        end
    end

    assign bus.ld_ready = (state_q == S_IDLE);
    assign bus.stall    = (state_q != S_IDLE);
    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.RAMI     = rami_q;
    assign bus.ld_done  = ld_done_q;
    assign bus.ld_err   = ld_err_q;

endmodule

`default_nettype wire

// File: tb/tb_load_unit.sv
//------------------------------------------------------------------------------
// tb_load_unit : randomized loads against a transaction-timeline reference model.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_load_unit;

    localparam int TMO = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    load_unit_if bus ();

    load_unit #(.TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    logic        e_ready, e_stall, e_req, e_done, e_err;
    logic [31:0] e_addr, e_rami;

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h required %08h at t=%0t", nm, got, exp, $time);
        end
    endtask

    // Legality straight from the width table and alignment rules.
    function automatic bit illegal(input logic [31:0] a, input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1'b0;
            3'd1, 3'd5: return a[0];
            3'd2:       return (a[1:0] != 2'd0);
            default:    return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] model_ext(input logic [31:0] w, input logic [1:0] off,
                                              input logic [2:0] f3);
        int unsigned b, h;
        b = (w >> (8 * int'(off))) & 32'hFF;
        h = (w >> (16 * (int'(off) / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128)   ? b - 256           : b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("ld_ready", {31'd0, bus.ld_ready}, {31'd0, e_ready});
            cmp("stall",    {31'd0, bus.stall},    {31'd0, e_stall});
            cmp("mem_req",  {31'd0, bus.mem_req},  {31'd0, e_req});
            cmp("ld_done",  {31'd0, bus.ld_done},  {31'd0, e_done});
            cmp("ld_err",   {31'd0, bus.ld_err},   {31'd0, e_err});
            cmp("mem_addr", bus.mem_addr, e_addr);
            cmp("RAMI",     bus.RAMI,     e_rami);
        end
    end

    task automatic set_idle_exp();
        e_ready = 1'b1; e_stall = 1'b0; e_req = 1'b0; e_done = 1'b0; e_err = 1'b0;
    endtask

    // Outside IDLE the request inputs are don't-care, so they carry noise.
    task automatic junk_ld();
        bus.ld_valid  = 1'($urandom);
        bus.ld_addr   = $urandom;
        bus.ld_funct3 = 3'($urandom);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            bus.ld_valid  = 1'b0;
            bus.ld_addr   = $urandom;
            bus.mem_ready = 1'($urandom);
            bus.mem_rdata = $urandom;
            set_idle_exp();
            @(posedge clk); #1;
        end
    endtask

    // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the next IDLE cycle.
    // k = request cycle on which RAM answers (0 = never); rst_cyc = request cycle to reset in.
    task automatic do_load(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] w,
                           input int k, input int rst_cyc);
        int  n;
        bit  hit;
        bus.ld_valid  = 1'b1;
        bus.ld_addr   = a;
        bus.ld_funct3 = f3;
        bus.mem_ready = 1'($urandom);
        bus.mem_rdata = $urandom;
        set_idle_exp();
        @(posedge clk); #1;
        if (illegal(a, f3)) begin
            junk_ld();
            bus.mem_ready = 1'($urandom);
            e_ready = 1'b0; e_stall = 1'b1; e_req = 1'b0; e_done = 1'b0; e_err = 1'b1;
            @(posedge clk); #1;
            bus.ld_valid = 1'b0;
            set_idle_exp();
            return;
        end
        hit    = (k >= 1 && k <= TMO);
        n      = hit ? k : TMO;
        e_addr = {a[31:2], 2'b00};
        for (int j = 1; j <= n; j++) begin
            junk_ld();
            bus.mem_ready = (j == k);
            bus.mem_rdata = (j == k) ? w : $urandom;
            e_ready = 1'b0; e_stall = 1'b1; e_req = 1'b1; e_done = 1'b0; e_err = 1'b0;
            if (j == rst_cyc) begin
                #2;
                set_idle_exp();
                e_addr = 32'd0;
                e_rami = 32'd0;
                bus.ld_valid  = 1'b0;
                bus.mem_ready = 1'b0;
                rst_n = 1'b0;
                #1;
                cmp("rst_async_mem_req", {31'd0, bus.mem_req}, 32'd0);
                cmp("rst_async_RAMI",    bus.RAMI,             32'd0);
                cmp("rst_async_stall",   {31'd0, bus.stall},   32'd0);
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
            @(posedge clk); #1;
        end
        junk_ld();
        bus.mem_ready = 1'($urandom);
        bus.mem_rdata = $urandom;
        e_ready = 1'b0; e_stall = 1'b1; e_req = 1'b0;
        e_done  = hit;
        e_err   = !hit;
        if (hit) e_rami = model_ext(w, a[1:0], f3);
        @(posedge clk); #1;
        bus.ld_valid = 1'b0;
        set_idle_exp();
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  f3;
        logic [2:0]  legal_codes [5];
        legal_codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        bus.ld_valid = 1'b0; bus.ld_addr = 32'd0; bus.ld_funct3 = 3'd0;
        bus.mem_ready = 1'b0; bus.mem_rdata = 32'd0;
        #1 rst_n = 1'b0;
        #1;
        cmp("reset_ld_ready", {31'd0, bus.ld_ready}, 32'd1);
        cmp("reset_stall",    {31'd0, bus.stall},    32'd0);
        cmp("reset_mem_req",  {31'd0, bus.mem_req},  32'd0);
        cmp("reset_ld_done",  {31'd0, bus.ld_done},  32'd0);
        cmp("reset_ld_err",   {31'd0, bus.ld_err},   32'd0);
        cmp("reset_mem_addr", bus.mem_addr, 32'd0);
        cmp("reset_RAMI",     bus.RAMI,     32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n  = 1'b1;
        e_addr = 32'd0;
        e_rami = 32'd0;
        set_idle_exp();
        chk_en = 1'b1;
        idle_cycles(1);

        do_load(32'h100, 3'd2, 32'hDEAD_BEEF, 1, 0);
        cmp("pin_lw_RAMI",     bus.RAMI,     32'hDEAD_BEEF);
        cmp("pin_lw_mem_addr", bus.mem_addr, 32'h0000_0100);
        do_load(32'h103, 3'd0, 32'h80FF_1234, 2, 0);
        cmp("pin_lb_RAMI",  bus.RAMI, 32'hFFFF_FF80);
        do_load(32'h103, 3'd4, 32'h80FF_1234, 1, 0);
        cmp("pin_lbu_RAMI", bus.RAMI, 32'h0000_0080);
        do_load(32'h102, 3'd1, 32'h8001_7FFF, 3, 0);
        cmp("pin_lh_RAMI",  bus.RAMI, 32'hFFFF_8001);
        do_load(32'h100, 3'd5, 32'h8001_7FFF, 1, 0);
        cmp("pin_lhu_RAMI", bus.RAMI, 32'h0000_7FFF);
        do_load(32'h101, 3'd2, 32'h1111_1111, 1, 0);
        cmp("pin_misalign_RAMI", bus.RAMI, 32'h0000_7FFF);
        do_load(32'h100, 3'd3, 32'h2222_2222, 1, 0);
        cmp("pin_illegal_RAMI",  bus.RAMI, 32'h0000_7FFF);
        do_load(32'h200, 3'd2, 32'h3333_3333, 0, 0);
        cmp("pin_timeout_RAMI",  bus.RAMI, 32'h0000_7FFF);
        do_load(32'h204, 3'd2, 32'hCAFE_F00D, TMO, 0);
        cmp("pin_ready_last_RAMI", bus.RAMI, 32'hCAFE_F00D);
        do_load(32'h300, 3'd2, 32'h1234_5678, 0, 3);
        idle_cycles(1);
        do_load(32'h040, 3'd2, 32'hA5A5_5A5A, 1, 0);
        cmp("pin_after_reset_RAMI", bus.RAMI, 32'hA5A5_5A5A);

        for (int i = 0; i < 150; i++) begin
            a = $urandom;
            if ($urandom_range(0, 9) < 8) begin
                f3 = legal_codes[$urandom_range(0, 4)];
                if ($urandom_range(0, 9) < 7) begin
                    if (f3 == 3'd2) a[1:0] = 2'd0;
                    if (f3 == 3'd1 || f3 == 3'd5) a[0] = 1'b0;
                end
            end else begin
                f3 = 3'($urandom);
            end
            do_load(a, f3, $urandom, $urandom_range(0, TMO + 2), 0);
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
        end

        idle_cycles(2);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
